// File: rtl/quad_pkg.sv
// -----------------------------------------------------------------------------
// quad_pkg
// Shared constants and types for the quadrature decoder slice.
//   DIR_UP / DIR_DOWN      : values driven on updown
//   phase_pair_t           : {a, b} phase pair as seen by the decoder
//   FILTER_LEN_MIN/MAX     : legal range of the glitch-filter run length
//   SYNC_STAGES            : depth of the per-phase synchronizer
//   pair_to_pos()          : maps a phase pair to its position on the
//                            forward cycle 00 -> 10 -> 11 -> 01 -> 00
// -----------------------------------------------------------------------------
package quad_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int FILTER_LEN_MIN = 2;
  localparam int FILTER_LEN_MAX = 15;

  localparam int SYNC_STAGES = 2;

  typedef struct packed {
    logic a;
    logic b;
  } phase_pair_t;

  // Position along the forward sequence. A forward step is +1 (mod 4),
  // a reverse step is -1, and a two-bit change is a distance of 2.
  function automatic logic [1:0] pair_to_pos(input phase_pair_t p);
    logic [1:0] pos;
    case ({p.a, p.b})
      2'b00:   pos = 2'd0;
      2'b10:   pos = 2'd1;
      2'b11:   pos = 2'd2;
      default: pos = 2'd3;
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/quad_filter.sv
// -----------------------------------------------------------------------------
// quad_filter
// One encoder phase: 2-flop synchronizer, optionally followed by a glitch
// filter (macro QUAD_DECODER_FILTER_EN). With the filter, the output level
// only changes after FILTER_LEN consecutive synchronized samples that all
// differ from the current output; any agreeing sample restarts the run.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   i_phase        : raw encoder phase, asynchronous to clock
//   o_phase        : synchronized (and filtered) phase level
// Parameter FILTER_LEN exists only when the filter is built; the caller
// passes an already range-clamped value.
// -----------------------------------------------------------------------------
module quad_filter
  import quad_pkg::*;
`ifdef QUAD_DECODER_FILTER_EN
#(
  parameter int FILTER_LEN = 4
)
`endif
(
  input  logic clock,
  input  logic reset_n,
  input  logic i_phase,
  output logic o_phase
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_phase};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef QUAD_DECODER_FILTER_EN
  localparam logic [3:0] RUN_LAST = 4'(FILTER_LEN - 1);

  logic [3:0] r_run;
  logic       r_level;

  // The sample that completes the run is itself counted, so the level
  // moves on the FILTER_LEN-th differing sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_run   <= '0;
      r_level <= 1'b0;
    end else if (w_sync == r_level) begin
      r_run <= '0;
    end else if (r_run == RUN_LAST) begin
      r_level <= w_sync;
      r_run   <= '0;
    end else begin
      r_run <= r_run + 4'd1;
    end
  end

  assign o_phase = r_level;
`else
  assign o_phase = w_sync;
`endif

endmodule

// File: rtl/quad_decoder.sv
// -----------------------------------------------------------------------------
// quad_decoder
// Quadrature encoder decoder producing count-enable / direction for a
// downstream up/down counter, plus a sticky illegal-transition flag.
// Optional glitch filter on each phase: define QUAD_DECODER_FILTER_EN.
// Ports:
//   clock     : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   enc_a/b   : encoder phases, asynchronous to clock
//   enable    : 1 = pulses may be generated; 0 = phase tracked only
//   err_clr   : synchronous clear of err_flag (a coincident error wins)
//   cin       : one-cycle count-enable pulse
//   updown    : count direction, 1 = up; holds while cin is low
//   err_flag  : sticky flag for two-bit phase changes
// Latency from a phase change to cin is 3 cycles, plus FILTER_LEN with the
// filter built.
// -----------------------------------------------------------------------------
module quad_decoder
  import quad_pkg::*;
#(
  parameter int FILTER_LEN = 4
)
(
  input  logic clock,
  input  logic reset_n,
  input  logic enc_a,
  input  logic enc_b,
  input  logic enable,
  input  logic err_clr,
  output logic cin,
  output logic updown,
  output logic err_flag
);

`ifdef QUAD_DECODER_FILTER_EN
  localparam int FILT_CYC = (FILTER_LEN < FILTER_LEN_MIN) ? FILTER_LEN_MIN :
                            (FILTER_LEN > FILTER_LEN_MAX) ? FILTER_LEN_MAX :
                            FILTER_LEN;
`else
  // Filter absent: FILTER_LEN contributes no settle time.
  localparam int FILT_CYC = 0 * FILTER_LEN;
`endif

  // Cycles after reset release until the decode input carries a real
  // sample of the pins rather than the pipeline's reset value. Priming on
  // that sample keeps a non-zero level at release from looking like a step.
  localparam int         WARM_CYC  = SYNC_STAGES + 1 + FILT_CYC;
  localparam logic [4:0] WARM_LAST = 5'(WARM_CYC - 1);

  logic        w_a;
  logic        w_b;
  phase_pair_t w_pair;
  logic [1:0]  w_delta;
  logic        w_active;
  logic        w_up;
  logic        w_dn;
  logic        w_illegal;

  phase_pair_t r_prev;
  logic        r_primed;
  logic [4:0]  r_warm;
  logic        r_cin;
  logic        r_updown;
  logic        r_err;

`ifdef QUAD_DECODER_FILTER_EN
  quad_filter #(.FILTER_LEN(FILT_CYC)) u_filt_a (
    .clock   (clock),
    .reset_n (reset_n),
    .i_phase (enc_a),
    .o_phase (w_a)
  );

  quad_filter #(.FILTER_LEN(FILT_CYC)) u_filt_b (
    .clock   (clock),
    .reset_n (reset_n),
    .i_phase (enc_b),
    .o_phase (w_b)
  );
`else
  quad_filter u_filt_a (
    .clock   (clock),
    .reset_n (reset_n),
    .i_phase (enc_a),
    .o_phase (w_a)
  );

  quad_filter u_filt_b (
    .clock   (clock),
    .reset_n (reset_n),
    .i_phase (enc_b),
    .o_phase (w_b)
  );
`endif

  assign w_pair = phase_pair_t'({w_a, w_b});

  // Distance along the forward cycle: 1 = forward, 3 = reverse,
  // 2 = both phases changed, 0 = no change.
  assign w_delta   = pair_to_pos(w_pair) - pair_to_pos(r_prev);
  assign w_active  = r_primed & enable;
  assign w_up      = w_active & (w_delta == 2'd1);
  assign w_dn      = w_active & (w_delta == 2'd3);
  assign w_illegal = w_active & (w_delta == 2'd2);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prev   <= '0;
      r_primed <= 1'b0;
      r_warm   <= '0;
      r_cin    <= 1'b0;
      r_updown <= DIR_UP;
      r_err    <= 1'b0;
    end else begin
      // prev tracks the pins every cycle, independent of enable.
      r_prev <= w_pair;
      r_cin  <= w_up | w_dn;

      if (w_up) begin
        r_updown <= DIR_UP;
      end else if (w_dn) begin
        r_updown <= DIR_DOWN;
      end

      if (w_illegal) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end

      if (!r_primed) begin
        if (r_warm == WARM_LAST) begin
          r_primed <= 1'b1;
        end else begin
          r_warm <= r_warm + 5'd1;
        end
      end
    end
  end

  assign cin      = r_cin;
  assign updown   = r_updown;
  assign err_flag = r_err;

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 4: consecutive identical samples required to accept a new encoder level; legal range 2..15.
REQ-002 The block SHALL have port clock, input, 1 bit: single rising-edge clock for all state.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port enc_a, input, 1 bit: encoder phase A, asynchronous to clock.
REQ-005 The block SHALL have port enc_b, input, 1 bit: encoder phase B, asynchronous to clock.
REQ-006 The block SHALL have port enable, input, 1 bit: 1 = pulses may be generated; 0 = phase is tracked, no pulses.
REQ-007 The block SHALL have port err_clr, input, 1 bit: synchronous clear of err_flag.
REQ-008 The block SHALL have port cin, output, 1 bit: one-cycle count-enable pulse, driving the downstream up/down counter cin.
REQ-009 The block SHALL have port updown, output, 1 bit: count direction (1 = up), driving the downstream counter updown.
REQ-010 The block SHALL have port err_flag, output, 1 bit: sticky illegal-transition flag.

Function
REQ-011 Each phase SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 The block SHALL hold a registered previous phase pair prev = {A,B} and a primed bit.
REQ-013 The forward sequence SHALL be 00->10->11->01->00, with A leading; each such step SHALL set cin=1 for exactly one cycle and updown=1.
REQ-014 The reverse sequence SHALL be 00->01->11->10->00; each such step SHALL set cin=1 for one cycle and updown=0.
REQ-015 An unchanged pair SHALL produce cin=0; updown SHALL hold its last value whenever cin=0.
REQ-016 A two-bit change (00<->11, 01<->10) SHALL produce cin=0 with updown unchanged, set err_flag, and load prev.
REQ-017 prev SHALL be updated every cycle from the filtered pair, regardless of enable.
REQ-018 With enable=0, cin SHALL be 0 and err_flag SHALL NOT be set.
REQ-019 With filtering absent, a phase change SHALL yield cin high in the cycle after the 3rd rising edge that samples the new level (fixed 3-cycle latency).
REQ-020 err_clr=1 SHALL clear err_flag; if err_clr coincides with a new illegal transition, the flag SHALL stay set (set wins).
REQ-021 One legal step SHALL produce exactly one cin pulse; steps arriving on consecutive filtered cycles SHALL produce back-to-back pulses.

Reset
REQ-022 While reset_n=0: cin=0, updown=1, err_flag=0, primed=0, synchronizer, filter and prev registers = 0.
REQ-023 The first filtered sample after reset release SHALL load prev and set primed without generating cin or err_flag, whatever the phase levels.
REQ-024 Reset asserted mid-pulse SHALL force cin low immediately (asynchronously).

Configuration
REQ-025 With macro QUAD_DECODER_FILTER_EN defined, each synchronized phase SHALL pass a glitch filter: the output level changes only after FILTER_LEN consecutive identical differing samples, the run counter resets on any mismatch, and latency grows by FILTER_LEN cycles.
REQ-026 With QUAD_DECODER_FILTER_EN undefined, the filter SHALL be absent, the synchronizer output SHALL feed decode directly, and FILTER_LEN SHALL be ignored.

Structure
REQ-027 Package quad_pkg SHALL hold the DIR_UP/DIR_DOWN constants, the phase-pair typedef and the FILTER_LEN range constants.
REQ-028 Sub-module quad_filter (synchronizer plus optional glitch filter, one phase) SHALL be instantiated once per phase.
REQ-029 Decode and error logic SHALL reside in quad_decoder; total RTL SHALL stay within 120-400 lines.

Verification
REQ-030 Reset, then 8 forward steps spaced 20 cycles apart -> 8 single cin pulses, updown=1, err_flag=0; downstream 8-bit q = 0x08.
REQ-031 4 forward steps then 6 reverse steps -> 10 pulses; updown flips to 0 on the 5th pulse; net count = -2 (q = 0xFE).
REQ-032 Jump 00->11 -> no cin pulse, err_flag=1; err_clr pulse -> err_flag=0; err_clr in the same cycle as a second illegal jump -> err_flag stays 1.
REQ-033 With FILTER_EN and FILTER_LEN=4, a 3-cycle glitch on enc_a -> no pulse; a 4-cycle stable change -> one pulse at latency 3+4.
REQ-034 Reset with phases at 11, then release -> no pulse; enable=0 during 3 steps -> no pulses; enable=1 and 1 step -> exactly one pulse.
